// File: rtl/fixed_to_float_pipe.sv
// fixed_to_float_pipe: three-stage converter from an unsigned Q1.20 magnitude
// plus sign into IEEE-754 single precision. S1 registers the request, S2 finds
// the leading one, S3 normalises and packs. One shared advance enable stalls
// every stage together, so bubbles are carried rather than collapsed.
module fixed_to_float_pipe #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [20:0]        in_data,
  input  logic               in_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_fp,
  output logic [COUNT_W-1:0] conv_count
);

  logic               adv;

  logic               s1_valid_q, s1_valid_d;
  logic [20:0]        s1_data_q,  s1_data_d;
  logic               s1_sign_q,  s1_sign_d;

  logic               s2_valid_q, s2_valid_d;
  logic [20:0]        s2_data_q,  s2_data_d;
  logic               s2_sign_q,  s2_sign_d;
  logic [4:0]         s2_pos_q,   s2_pos_d;
  logic               s2_zero_q,  s2_zero_d;

  logic               s3_valid_q, s3_valid_d;
  logic [31:0]        out_fp_q,   out_fp_d;

  logic [COUNT_W-1:0] count_q,    count_d;

  logic [4:0]         lod_pos;
  logic               lod_zero;
  logic [19:0]        mant;
  logic [7:0]         expo;

  assign adv        = out_ready | ~s3_valid_q;
  assign in_ready   = adv;
  assign out_valid  = s3_valid_q;
  assign out_fp     = out_fp_q;
  assign conv_count = count_q;

  // Leading-one detector on the S1 magnitude; ascending scan so the MSB wins.
  always_comb begin
    lod_pos  = '0;
    lod_zero = 1'b1;
    for (int unsigned i = 0; i < 21; i++) begin
      if (s1_data_q[i]) begin
        lod_pos  = 5'(20 - i);
        lod_zero = 1'b0;
      end
    end
  end

  // Normalise and pack: the implicit one falls off the top of the shift.
  always_comb begin
    mant = 20'(s2_data_q << s2_pos_q);
    expo = 8'd127 - {3'b000, s2_pos_q};
  end

  // Next-state for all stages under the shared advance enable, plus counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_sign_d  = s1_sign_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sign_d  = s2_sign_q;
    s2_pos_d   = s2_pos_q;
    s2_zero_d  = s2_zero_q;
    s3_valid_d = s3_valid_q;
    out_fp_d   = out_fp_q;
    count_d    = count_q;
    if (adv) begin
      s1_valid_d = in_valid;
      s1_data_d  = in_data;
      s1_sign_d  = in_sign;
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_data_q;
      s2_sign_d  = s1_sign_q;
      s2_pos_d   = lod_pos;
      s2_zero_d  = lod_zero;
      s3_valid_d = s2_valid_q;
      // Zero input packs to +0 regardless of sign.
      out_fp_d   = s2_zero_q ? '0 : {s2_sign_q, expo, mant, 3'b000};
    end
    if (s3_valid_q && out_ready) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_sign_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sign_q  <= 1'b0;
      s2_pos_q   <= '0;
      s2_zero_q  <= 1'b1;
      s3_valid_q <= 1'b0;
      out_fp_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_sign_q  <= s1_sign_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sign_q  <= s2_sign_d;
      s2_pos_q   <= s2_pos_d;
      s2_zero_q  <= s2_zero_d;
      s3_valid_q <= s3_valid_d;
      out_fp_q   <= out_fp_d;
      count_q    <= count_d;
    end
  end

endmodule
